// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and instruction-field positions for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;

endpackage

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// Combinational load-use hazard comparator between the EX load and the ID source registers.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] i_id_inst,
    input  logic        i_ex_memread,
    input  logic [4:0]  i_ex_rd,
    output logic        o_luh
);

    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_unused_inst_bits;

    assign w_rs1 = i_id_inst[RS1_MSB:RS1_LSB];
    assign w_rs2 = i_id_inst[RS2_MSB:RS2_LSB];
    assign w_unused_inst_bits = ^{i_id_inst[31:25], i_id_inst[14:0]};

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign o_luh = i_ex_memread && (i_ex_rd != 5'd0) &&
                   ((i_ex_rd == w_rs1) || (i_ex_rd == w_rs2));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Prioritised stall/flush sequencer for the 5-stage pipeline with saturating perf counters.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_inst,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_t             r_state;
    logic               r_br_pend;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_mem_timeout;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic [CNT_W-1:0]   r_flush_count;

    logic               w_luh;
    logic               w_freeze;
    logic               w_flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    load_use_detect u_load_use_detect (
        .i_id_inst    (id_inst),
        .i_ex_memread (ex_memread),
        .i_ex_rd      (ex_rd),
        .o_luh        (w_luh)
    );

    // A freeze in RUN is the first wait cycle; in MEM_WAIT it lasts until ready
    assign w_freeze = (r_state == RUN) ? (mem_req && !mem_ready) : !mem_ready;
    assign w_flush  = !w_freeze && (ex_branch_taken || r_br_pend);

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        exmem_we     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst_n) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (w_freeze) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (w_flush) begin
            // The ID instruction is discarded, so any load-use hit is moot
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (w_luh) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_flush   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_br_pend      <= 1'b0;
            r_wait_cnt     <= '0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state   <= w_freeze ? MEM_WAIT : RUN;
            // A branch resolved during a freeze is held until the freeze ends
            r_br_pend <= w_freeze ? (r_br_pend || ex_branch_taken) : 1'b0;
            if (!w_freeze) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if ((r_state == MEM_WAIT) && (r_wait_cnt == WAIT_MAX)) begin
                r_mem_timeout <= 1'b1;
            end
            if (!pc_we) begin
                r_stall_cycles <= sat_inc(r_stall_cycles);
            end
            if (w_flush) begin
                r_flush_count <= sat_inc(r_flush_count);
            end
        end
    end

    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: directed vectors push expected controls/counters, a negedge monitor compares.
module tb_pipeline_stall_controller;

    localparam logic [6:0] NRM = 7'b1111_000;
    localparam logic [6:0] LUH = 7'b0011_010;
    localparam logic [6:0] FLS = 7'b1111_110;
    localparam logic [6:0] FRZ = 7'b0000_001;
    localparam logic [6:0] RST = 7'b0000_111;

    typedef struct {
        string      name;
        logic [6:0] ctl;
        logic       tmo;
        int         stall;
        int         flush;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_inst = 32'h0072_8033;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_branch_taken = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_we, ifid_we, idex_we, exmem_we;
    logic        ifid_flush, idex_flush, memwb_bubble, mem_timeout;
    logic [31:0] stall_cycles, flush_count;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MAX_WAIT(4), .CNT_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_inst         (id_inst),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .idex_we         (idex_we),
        .exmem_we        (exmem_we),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_bubble    (memwb_bubble),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic step(input string nm, input logic r, input logic ld, input logic [4:0] rd,
                        input logic br, input logic rq, input logic rdy,
                        input logic [6:0] c, input logic t, input int s, input int f);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = r;
        ex_memread      = ld;
        ex_rd           = rd;
        ex_branch_taken = br;
        mem_req         = rq;
        mem_ready       = rdy;
        e.name  = nm;
        e.ctl   = c;
        e.tmo   = t;
        e.stall = s;
        e.flush = f;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble};
                n_checks++;
                if (act !== e.ctl || mem_timeout !== e.tmo ||
                    stall_cycles !== 32'(e.stall) || flush_count !== 32'(e.flush)) begin
                    n_fail++;
                    $display("FAIL %s: got ctl=%b tmo=%b stall=%0d flush=%0d, want ctl=%b tmo=%b stall=%0d flush=%0d",
                             e.name, act, mem_timeout, stall_cycles, flush_count,
                             e.ctl, e.tmo, e.stall, e.flush);
                end
            end
        end
    end

    initial begin : stim
        //    name        rst ld rd  br rq rdy  ctl  tmo  S   F
        step("reset_hold", 0, 0, 0,  0, 0, 0,  RST, 0,   0,  0);
        step("idle",       1, 0, 0,  0, 0, 0,  NRM, 0,   0,  0);
        step("luh_rs1",    1, 1, 5,  0, 0, 0,  LUH, 0,   0,  0);
        step("luh_rs2",    1, 1, 7,  0, 0, 0,  LUH, 0,   1,  0);
        step("no_luh_rd3", 1, 1, 3,  0, 0, 0,  NRM, 0,   2,  0);
        step("no_luh_x0",  1, 1, 0,  0, 0, 0,  NRM, 0,   2,  0);
        step("br_over_luh",1, 1, 5,  1, 0, 0,  FLS, 0,   2,  0);
        step("after_br",   1, 0, 0,  0, 0, 0,  NRM, 0,   2,  1);
        step("wait1",      1, 0, 0,  0, 1, 0,  FRZ, 0,   2,  1);
        step("wait2",      1, 0, 0,  0, 1, 0,  FRZ, 0,   3,  1);
        step("wait3",      1, 0, 0,  0, 1, 0,  FRZ, 0,   4,  1);
        step("wait_done",  1, 0, 0,  0, 1, 1,  NRM, 0,   5,  1);
        step("post_wait",  1, 0, 0,  0, 0, 0,  NRM, 0,   5,  1);
        step("dbr_w1",     1, 0, 0,  0, 1, 0,  FRZ, 0,   5,  1);
        step("dbr_w2_br",  1, 0, 0,  1, 1, 0,  FRZ, 0,   6,  1);
        step("dbr_w3",     1, 0, 0,  0, 1, 0,  FRZ, 0,   7,  1);
        step("dbr_ready",  1, 0, 0,  0, 1, 1,  FLS, 0,   8,  1);
        step("dbr_after",  1, 0, 0,  0, 0, 0,  NRM, 0,   8,  2);
        step("req_rdy_run",1, 0, 0,  0, 1, 1,  NRM, 0,   8,  2);
        step("tmo_w1",     1, 0, 0,  0, 1, 0,  FRZ, 0,   8,  2);
        step("tmo_w2",     1, 0, 0,  0, 1, 0,  FRZ, 0,   9,  2);
        step("tmo_w3",     1, 0, 0,  0, 1, 0,  FRZ, 0,  10,  2);
        step("tmo_w4",     1, 0, 0,  0, 1, 0,  FRZ, 0,  11,  2);
        step("tmo_w5",     1, 0, 0,  0, 1, 0,  FRZ, 0,  12,  2);
        step("tmo_w6",     1, 0, 0,  0, 1, 0,  FRZ, 1,  13,  2);
        step("tmo_ready",  1, 0, 0,  0, 1, 1,  NRM, 1,  14,  2);
        step("tmo_sticky", 1, 0, 0,  0, 0, 0,  NRM, 1,  14,  2);
        step("rst_w1",     1, 0, 0,  0, 1, 0,  FRZ, 1,  14,  2);
        step("rst_midwait",0, 0, 0,  0, 1, 0,  RST, 0,   0,  0);
        step("rst_held",   0, 0, 0,  0, 0, 0,  RST, 0,   0,  0);
        step("rst_release",1, 0, 0,  0, 0, 0,  NRM, 0,   0,  0);
        step("rst_idle",   1, 0, 0,  0, 0, 0,  NRM, 0,   0,  0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
